// File: rtl/dds_core.sv
// dds_core: phase-accumulator waveform generator sitting behind the DDS register map.
// Sine, square, saw and triangle samples share one two-stage output pipeline.
module dds_core #(
    parameter int SIG_WIDTH = 16,
    parameter int PHASE_W   = 32,
    parameter int LUT_AW    = 10
) (
    input  logic                        clk,
    input  logic                        a_rst_n,
    input  logic [31:0]                 i_ctrl_reg,
    input  logic [31:0]                 i_data_reg,
    input  logic [31:0]                 i_clk_div_reg,
    input  logic [31:0]                 i_lngth_reg,
    output logic signed [SIG_WIDTH-1:0] o_dds_signal,
    output logic                        o_dds_valid,
    output logic                        o_dds_busy,
    output logic                        o_dds_done
);

    localparam int LUT_SIZE = 2 ** LUT_AW;
    localparam int MAX_AMP  = 2 ** (SIG_WIDTH - 1) - 1;
    localparam real PI      = 3.14159265358979323846;
    localparam logic signed [SIG_WIDTH-1:0] POS_FULL = SIG_WIDTH'(MAX_AMP);
    localparam logic signed [SIG_WIDTH-1:0] NEG_FULL = SIG_WIDTH'(-MAX_AMP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                        en, oneshot, phase_clr;
    logic [1:0]                  wave;
    logic                        ctrl_unused;
    logic [PHASE_W-1:0]          phase;
    logic [31:0]                 div_cnt, smp_cnt, lngth_q;
    logic                        tick, last, burst_start, empty_burst;
    logic signed [SIG_WIDTH-1:0] calc;
    logic [SIG_WIDTH-1:0]        saw_t, tri_field, tri_u;
    logic                        s1_valid, s1_last, s1_is_sine;
    logic signed [SIG_WIDTH-1:0] s1_sine, s1_calc;
    logic signed [SIG_WIDTH-1:0] sine_rom [LUT_SIZE];

    assign en          = i_ctrl_reg[0];
    assign oneshot     = i_ctrl_reg[1];
    assign wave        = i_ctrl_reg[3:2];
    assign phase_clr   = i_ctrl_reg[4];
    assign ctrl_unused = ^i_ctrl_reg[31:5];

    // Table entries are round(M * sin(2*pi*i/N)), computed at elaboration time.
    function automatic logic signed [SIG_WIDTH-1:0] sine_entry(input int idx);
        real v;
        v = real'(MAX_AMP) * $sin(2.0 * PI * real'(idx) / real'(LUT_SIZE));
        if (v >= 0.0)
            return SIG_WIDTH'($rtoi(v + 0.5));
        else
            return SIG_WIDTH'(-$rtoi(0.5 - v));
    endfunction

    for (genvar i = 0; i < LUT_SIZE; i++) begin : g_rom
        localparam logic signed [SIG_WIDTH-1:0] ENTRY = sine_entry(i);
        assign sine_rom[i] = ENTRY;
    end

    always_comb begin
        state_nxt   = state;
        tick        = 1'b0;
        last        = 1'b0;
        burst_start = 1'b0;
        empty_burst = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (oneshot && (i_lngth_reg == 32'd0)) begin
                        state_nxt   = DONE;
                        empty_burst = 1'b1;
                    end else begin
                        state_nxt   = RUN;
                        burst_start = 1'b1;
                    end
                end
            end
            RUN: begin
                tick = (div_cnt >= i_clk_div_reg);
                if (!en) begin
                    state_nxt = IDLE;
                end else if (tick && oneshot && (smp_cnt + 32'd1 == lngth_q)) begin
                    state_nxt = DONE;
                    last      = 1'b1;
                end
            end
            DONE: begin
                if (!en)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Non-sine waves are derived directly from the top phase bits of the ticked sample.
    always_comb begin
        saw_t     = phase[PHASE_W-1 -: SIG_WIDTH];
        tri_field = phase[PHASE_W-2 -: SIG_WIDTH];
        tri_u     = phase[PHASE_W-1] ? ~tri_field : tri_field;
        calc      = '0;
        case (wave)
            2'd1:    calc = phase[PHASE_W-1] ? NEG_FULL : POS_FULL;
            2'd2:    calc = {~saw_t[SIG_WIDTH-1], saw_t[SIG_WIDTH-2:0]};
            2'd3:    calc = {~tri_u[SIG_WIDTH-1], tri_u[SIG_WIDTH-2:0]};
            default: calc = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!a_rst_n) begin
            state   <= IDLE;
            phase   <= '0;
            div_cnt <= '0;
            smp_cnt <= '0;
            lngth_q <= '0;
        end else begin
            state <= state_nxt;
            if (phase_clr)
                phase <= '0;
            else if (tick)
                phase <= phase + i_data_reg[PHASE_W-1:0];
            if (state == RUN)
                div_cnt <= tick ? 32'd0 : div_cnt + 32'd1;
            else
                div_cnt <= '0;
            if (burst_start) begin
                smp_cnt <= '0;
                lngth_q <= i_lngth_reg;
            end else if (tick) begin
                smp_cnt <= smp_cnt + 32'd1;
            end
        end
    end

    // Stage 1 holds the ROM read and computed sample; stage 2 drives the outputs.
    always_ff @(posedge clk) begin
        if (!a_rst_n) begin
            s1_valid     <= 1'b0;
            s1_last      <= 1'b0;
            s1_is_sine   <= 1'b0;
            s1_sine      <= '0;
            s1_calc      <= '0;
            o_dds_valid  <= 1'b0;
            o_dds_done   <= 1'b0;
            o_dds_signal <= '0;
        end else begin
            s1_valid <= tick;
            if (tick) begin
                s1_last    <= last;
                s1_is_sine <= (wave == 2'd0);
                s1_sine    <= sine_rom[phase[PHASE_W-1 -: LUT_AW]];
                s1_calc    <= calc;
            end
            o_dds_valid <= s1_valid;
            o_dds_done  <= (s1_valid && s1_last) || empty_burst;
            if (s1_valid)
                o_dds_signal <= s1_is_sine ? s1_sine : s1_calc;
        end
    end

    assign o_dds_busy = (state == RUN) || s1_valid || o_dds_valid;

endmodule

// File: tb/tb_dds_core.sv
// tb_dds_core: directed and randomized stimulus for dds_core, checked every cycle
// against a sample-queue reference model of the generator.
module tb_dds_core;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} model_state_t;

    typedef struct {
        int due;
        int value;
        bit last;
    } sample_t;

    logic               clk;
    logic               a_rst_n;
    logic [31:0]        i_ctrl_reg, i_data_reg, i_clk_div_reg, i_lngth_reg;
    logic signed [15:0] o_dds_signal;
    logic               o_dds_valid, o_dds_busy, o_dds_done;

    int pass_count = 0;
    int check_count = 0;
    int cyc = 0;
    int done_seen = 0;
    int obs_q [$];

    model_state_t m_state = M_IDLE;
    logic [31:0]  m_phase = '0;
    logic [31:0]  m_since = '0;
    logic [31:0]  m_count = '0;
    logic [31:0]  m_lngth = '0;
    int           m_signal = 0;
    int           m_done_at = -1;
    sample_t      exp_q [$];

    dds_core dut (
        .clk           (clk),
        .a_rst_n       (a_rst_n),
        .i_ctrl_reg    (i_ctrl_reg),
        .i_data_reg    (i_data_reg),
        .i_clk_div_reg (i_clk_div_reg),
        .i_lngth_reg   (i_lngth_reg),
        .o_dds_signal  (o_dds_signal),
        .o_dds_valid   (o_dds_valid),
        .o_dds_busy    (o_dds_busy),
        .o_dds_done    (o_dds_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sine_ref(input int k);
        real v;
        v = 32767.0 * $sin(2.0 * PI * real'(k) / 1024.0);
        if (v >= 0.0)
            return $rtoi(v + 0.5);
        else
            return -$rtoi(0.5 - v);
    endfunction

    // Sample value for phase p, written as plain arithmetic on the phase word.
    function automatic int wave_ref(input logic [31:0] p, input int w);
        longint pu;
        int t;
        int u;
        pu = longint'(p);
        case (w)
            0: return sine_ref(int'(pu / 4194304));
            1: return (pu < 64'sd2147483648) ? 32767 : -32767;
            2: return int'(pu / 65536) - 32768;
            default: begin
                t = int'((pu / 32768) % 65536);
                u = (pu >= 64'sd2147483648) ? (65535 - t) : t;
                return u - 32768;
            end
        endcase
    endfunction

    function automatic logic [31:0] mk_ctrl(input bit en, input bit one, input int wave, input bit clr);
        logic [1:0] w2;
        w2 = wave[1:0];
        return {27'd0, clr, w2, one, en};
    endfunction

    function automatic int obs_at(input int i);
        if (i < obs_q.size())
            return obs_q[i];
        return -99999;
    endfunction

    task automatic checkValue(input string tag, input int observed, input int expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, observed, expected);
    endtask

    task automatic checkOutput(input bit exp_valid, input int exp_signal, input bit exp_done, input bit exp_busy);
        check_count++;
        assert (o_dds_valid === exp_valid) pass_count++;
        else $error("[TB] FAIL valid cyc=%0d observed=%0b expected=%0b", cyc, o_dds_valid, exp_valid);
        check_count++;
        assert (int'(o_dds_signal) === exp_signal) pass_count++;
        else $error("[TB] FAIL signal cyc=%0d observed=%0d expected=%0d", cyc, o_dds_signal, exp_signal);
        check_count++;
        assert (o_dds_done === exp_done) pass_count++;
        else $error("[TB] FAIL done cyc=%0d observed=%0b expected=%0b", cyc, o_dds_done, exp_done);
        check_count++;
        assert (o_dds_busy === exp_busy) pass_count++;
        else $error("[TB] FAIL busy cyc=%0d observed=%0b expected=%0b", cyc, o_dds_busy, exp_busy);
    endtask

    // Drive one cycle of inputs, advance the model, clock the DUT and compare.
    task automatic applyStimulus(input logic rst_val, input logic [31:0] ctrl, input logic [31:0] data,
                                 input logic [31:0] div, input logic [31:0] lngth);
        bit           en_b, one_b, clr_b, tick, last, exp_valid, exp_done, exp_busy;
        int           wave_i;
        logic [31:0]  p;
        model_state_t prev;
        sample_t      s;
        a_rst_n       = rst_val;
        i_ctrl_reg    = ctrl;
        i_data_reg    = data;
        i_clk_div_reg = div;
        i_lngth_reg   = lngth;
        en_b   = ctrl[0];
        one_b  = ctrl[1];
        wave_i = int'(ctrl[3:2]);
        clr_b  = ctrl[4];
        if (!rst_val) begin
            m_state   = M_IDLE;
            m_phase   = '0;
            m_since   = '0;
            m_count   = '0;
            m_lngth   = '0;
            m_signal  = 0;
            m_done_at = -1;
            exp_q.delete();
        end else begin
            prev = m_state;
            p    = m_phase;
            tick = (prev == M_RUN) && (m_since >= div);
            last = 1'b0;
            if (tick) begin
                m_count = m_count + 32'd1;
                last    = en_b && one_b && (m_count == m_lngth);
                s.due   = cyc + 2;
                s.value = wave_ref(p, wave_i);
                s.last  = last;
                exp_q.push_back(s);
            end
            case (prev)
                M_IDLE: begin
                    if (en_b) begin
                        if (one_b && lngth == 32'd0) begin
                            m_state   = M_DONE;
                            m_done_at = cyc + 1;
                        end else begin
                            m_state = M_RUN;
                            m_count = '0;
                            m_lngth = lngth;
                        end
                    end
                end
                M_RUN: begin
                    if (!en_b)
                        m_state = M_IDLE;
                    else if (last)
                        m_state = M_DONE;
                end
                default: begin
                    if (!en_b)
                        m_state = M_IDLE;
                end
            endcase
            m_since = (prev == M_RUN) ? (tick ? 32'd0 : m_since + 32'd1) : 32'd0;
            m_phase = clr_b ? 32'd0 : (tick ? p + data : p);
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_valid = 1'b0;
        exp_done  = (m_done_at == cyc);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_valid = 1'b1;
            m_signal  = exp_q[0].value;
            exp_done  = exp_done || exp_q[0].last;
            void'(exp_q.pop_front());
        end
        exp_busy = (m_state == M_RUN) || exp_valid || (exp_q.size() > 0);
        checkOutput(exp_valid, m_signal, exp_done, exp_busy);
        if (o_dds_valid === 1'b1)
            obs_q.push_back(int'(o_dds_signal));
        if (o_dds_done === 1'b1)
            done_seen++;
    endtask

    initial begin
        logic [31:0] r_ctrl, r_data, r_div, r_lngth;
        logic        r_rst;
        int          n;

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

        $display("[TB] square continuous");
        obs_q.delete();
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, mk_ctrl(1, 0, 1, 0), 32'h4000_0000, 32'd0, 32'd0);
        checkValue("sq0", obs_at(0), 32767);
        checkValue("sq1", obs_at(1), 32767);
        checkValue("sq2", obs_at(2), -32767);
        checkValue("sq3", obs_at(3), -32767);
        checkValue("sq4", obs_at(4), 32767);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, mk_ctrl(0, 0, 1, 0), 32'h4000_0000, 32'd0, 32'd0);

        $display("[TB] divider");
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, mk_ctrl(1, 0, 2, 0), 32'h0100_0000, 32'd3, 32'd0);
        for (int i = 0; i < 8 && m_since != 32'd2; i++)
            applyStimulus(1'b1, mk_ctrl(1, 0, 2, 0), 32'h0100_0000, 32'd3, 32'd0);
        checkValue("div_cnt_reached_2", int'(m_since), 2);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, mk_ctrl(1, 0, 2, 0), 32'h0100_0000, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, mk_ctrl(0, 0, 2, 0), 32'h0100_0000, 32'd0, 32'd0);

        $display("[TB] oneshot burst");
        applyStimulus(1'b1, mk_ctrl(0, 0, 2, 1), 32'd0, 32'd0, 32'd0);
        obs_q.delete();
        done_seen = 0;
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, mk_ctrl(1, 1, 2, 0), 32'h1000_0000, 32'd0, 32'd5);
        checkValue("burst_count", obs_q.size(), 5);
        checkValue("burst0", obs_at(0), -32768);
        checkValue("burst1", obs_at(1), -28672);
        checkValue("burst2", obs_at(2), -24576);
        checkValue("burst3", obs_at(3), -20480);
        checkValue("burst4", obs_at(4), -16384);
        checkValue("burst_done", done_seen, 1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, mk_ctrl(0, 1, 2, 0), 32'h1000_0000, 32'd0, 32'd5);

        $display("[TB] empty oneshot");
        obs_q.delete();
        done_seen = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, mk_ctrl(1, 1, 1, 0), 32'h1000_0000, 32'd0, 32'd0);
        checkValue("empty_valids", obs_q.size(), 0);
        checkValue("empty_done", done_seen, 1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, mk_ctrl(0, 1, 1, 0), 32'h1000_0000, 32'd0, 32'd0);

        $display("[TB] sine");
        applyStimulus(1'b1, mk_ctrl(0, 0, 0, 1), 32'd0, 32'd0, 32'd0);
        obs_q.delete();
        for (int i = 0; i < 1030; i++) applyStimulus(1'b1, mk_ctrl(1, 0, 0, 0), 32'h0040_0000, 32'd0, 32'd0);
        checkValue("sine0", obs_at(0), 0);
        checkValue("sine1", obs_at(1), 201);
        checkValue("sine256", obs_at(256), 32767);
        checkValue("sine768", obs_at(768), -32767);
        checkValue("sine_wrap", obs_at(1024), 0);
        applyStimulus(1'b1, mk_ctrl(1, 0, 0, 1), 32'h0040_0000, 32'd0, 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, mk_ctrl(1, 0, 0, 0), 32'h0040_0000, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, mk_ctrl(0, 0, 0, 0), 32'h0040_0000, 32'd0, 32'd0);

        $display("[TB] enable dropped mid-burst");
        done_seen = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, mk_ctrl(1, 1, 3, 0), 32'h0765_4321, 32'd1, 32'd20);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, mk_ctrl(0, 1, 3, 0), 32'h0765_4321, 32'd1, 32'd20);
        checkValue("en_drop_done", done_seen, 0);

        $display("[TB] reset mid-burst");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, mk_ctrl(1, 1, 3, 0), 32'h0123_4567, 32'd0, 32'd20);
        applyStimulus(1'b0, mk_ctrl(1, 1, 3, 0), 32'h0123_4567, 32'd0, 32'd20);
        obs_q.delete();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd0, 32'h0123_4567, 32'd0, 32'd20);
        checkValue("post_reset_valids", obs_q.size(), 0);

        $display("[TB] randomized");
        for (int seg = 0; seg < 60; seg++) begin
            r_ctrl  = mk_ctrl($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                              int'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
            r_data  = $urandom;
            r_div   = $urandom_range(0, 3);
            r_lngth = $urandom_range(0, 6);
            r_rst   = ($urandom_range(0, 40) != 0);
            n       = int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) applyStimulus(r_rst, r_ctrl, r_data, r_div, r_lngth);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd0, 32'd0, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
